gate_send: RTL
==============

Name: gate_send

Overview:
Transmit-side routing gate, the egress counterpart of the receive gate. The host programs a per-source capability table, one entry per user-logic (UL) region. Each outgoing packet from a UL region is checked against its source's entry at the first beat. An authorised packet is forwarded with that entry's 8-bit route tag on a sideband. An unauthorised packet is silently dropped and counted. The block sits between the UL egress AXI-stream and the network/DTU egress.

Parameters:
N_SRCS, 4, number of UL source regions (1..4; indexed by 2-bit id).
DATA_W, 64, stream data width in bits.
CNT_W, 16, drop-counter width.

Ports:
aclk  in  1  clock
areset  in  1  synchronous, active-high reset
host_route_cap_valid  in  1  capability write strobe
host_route_cap_in  in  16  [1:0] source id, [2] enable, [7:3] reserved, [15:8] route tag
s_axis_tvalid  in  1  UL egress beat valid
s_axis_tready  out  1  UL egress ready
s_axis_tdata  in  DATA_W  beat data
s_axis_tlast  in  1  last beat of packet
s_axis_tid  in  2  source UL id; sampled on the first beat only
m_axis_tvalid  out  1  egress beat valid
m_axis_tready  in  1  egress ready
m_axis_tdata  out  DATA_W  egress data
m_axis_tlast  out  1  egress last
m_route_out  out  8  route tag; constant for the whole packet
drop_cnt_out  out  CNT_W  dropped-packet count
drop_pulse  out  1  one-cycle pulse per dropped packet

Behaviour:
- Reset (areset=1 at a clock edge):
  - All outputs go to 0, including s_axis_tready.
  - Every table entry becomes enable=0, tag=0x00.
  - FSM returns to IDLE.
  - Reset mid-packet discards the output-register beat; no tlast is emitted for the truncated packet.
- Capability table:
  - A write when host_route_cap_valid=1 updates entry[id] (enable and tag) at that edge; it is visible to lookups from the next cycle.
  - Writes with id >= N_SRCS are ignored.
  - A first-beat lookup in the same cycle as a write to the same id uses the old entry.
  - A write during an in-flight packet does not change that packet's latched tag.
- Output stage: a single register.
  - out_free = !m_axis_tvalid || m_axis_tready.
  - Latency is 1 cycle from input acceptance to m_axis_tvalid.
  - While m_axis_tvalid=1 && m_axis_tready=0, data, last and route are held stable.
  - m_axis_tvalid drops after a handshake unless a new beat loads in the same cycle.
- FSM states: IDLE, FWD, DROP.
  - IDLE: s_axis_tready = out_free. On an accepted beat, check ok = (tid < N_SRCS) && entry[tid].enable.
    - ok: load the beat into the output register; latch the tag into m_route_out. Next state is FWD, or stays IDLE if tlast.
    - !ok: discard the beat; pulse drop_pulse next cycle; increment drop_cnt_out (saturating at all-ones). Next state is DROP, or stays IDLE if tlast.
  - FWD: s_axis_tready = out_free. Each accepted beat is loaded with the latched tag. An accepted tlast returns to IDLE.
  - DROP: s_axis_tready = 1 (drains regardless of egress backpressure). Accepted beats are discarded. An accepted tlast returns to IDLE. No further drop_pulse is raised.
- Single-beat packets (tlast on the first beat) are handled in IDLE with no extra cycle. Back-to-back packets run at full throughput when m_axis_tready=1.
- s_axis_tid is ignored on non-first beats.
- The counter is updated only on the drop decision. drop_pulse and the counter increment are registered together.

Test Plan:
- Reset, then write cap {id=1, en=1, tag=0xA5}. Send a 3-beat packet tid=1, data 1,2,3, with m_axis_tready=1. -> Egress carries 1,2,3 with tlast on beat 3, m_route_out=0xA5 on all beats, 1-cycle latency, drop_cnt_out=0.
- No cap programmed for tid=2. Send a 4-beat packet. -> No egress beats; s_axis_tready=1 for all beats; drop_pulse high exactly 1 cycle; drop_cnt_out=1. A following authorised tid=1 packet forwards normally.
- Forwarding with m_axis_tready held 0 for 5 cycles mid-packet. -> s_axis_tready=0 and output held stable throughout; no beat lost or duplicated after release.
- Write {id=1, en=1, tag=0x3C} during beat 2 of an in-flight tid=1 packet. -> That packet keeps 0xA5; the next packet carries 0x3C. Write {id=1, en=0} in the same cycle as a first beat. -> That packet is forwarded; the next tid=1 packet is dropped.
- Write with id=3 while N_SRCS=2, then send tid=3. -> Write ignored; packet dropped; drop_cnt_out increments by 1. With CNT_W=2, 5 drops -> counter saturates at 3.
- Assert areset mid-packet in FWD with a beat pending. -> Next cycle: m_axis_tvalid=0, s_axis_tready=0, drop_cnt_out=0, all entries disabled. The post-reset packet from tid=1 is dropped until reprogrammed.

Source files
------------

// File: rtl/gate_send.sv
// Egress routing gate: checks each UL packet against a host-programmed per-source
// capability table, forwards authorised packets with a route tag, drops and counts the rest.
module gate_send #(
    parameter int unsigned N_SRCS = 4,
    parameter int unsigned DATA_W = 64,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              aclk,
    input  logic              areset,
    input  logic              host_route_cap_valid,
    input  logic [15:0]       host_route_cap_in,
    input  logic              s_axis_tvalid,
    output logic              s_axis_tready,
    input  logic [DATA_W-1:0] s_axis_tdata,
    input  logic              s_axis_tlast,
    input  logic [1:0]        s_axis_tid,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic [DATA_W-1:0] m_axis_tdata,
    output logic              m_axis_tlast,
    output logic [7:0]        m_route_out,
    output logic [CNT_W-1:0]  drop_cnt_out,
    output logic              drop_pulse
);

    typedef enum logic [1:0] {IDLE, FWD, DROP} state_t;

    state_t     state;
    logic       run;
    logic [3:0] cap_en;
    logic [7:0] cap_tag [4];
    logic [1:0] wr_id;
    logic       wr_ok;
    logic       out_free;
    logic       accept;
    logic       first_ok;
    logic       cap_unused;

    assign wr_id      = host_route_cap_in[1:0];
    assign wr_ok      = host_route_cap_valid && (32'(wr_id) < N_SRCS);
    assign cap_unused = ^host_route_cap_in[7:3];
    assign out_free   = !m_axis_tvalid || m_axis_tready;
    assign accept     = s_axis_tvalid && s_axis_tready;
    assign first_ok   = (32'(s_axis_tid) < N_SRCS) && cap_en[s_axis_tid];

    // run holds tready low through reset; DROP drains regardless of egress backpressure.
    always_comb begin
        s_axis_tready = 1'b0;
        if (run) begin
            s_axis_tready = (state == DROP) ? 1'b1 : out_free;
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state         <= IDLE;
            run           <= 1'b0;
            cap_en        <= '0;
            for (int unsigned i = 0; i < 4; i++) begin
                cap_tag[i] <= '0;
            end
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tlast  <= 1'b0;
            m_route_out   <= '0;
            drop_cnt_out  <= '0;
            drop_pulse    <= 1'b0;
        end else begin
            run        <= 1'b1;
            drop_pulse <= 1'b0;

            if (wr_ok) begin
                cap_en[wr_id]  <= host_route_cap_in[2];
                cap_tag[wr_id] <= host_route_cap_in[15:8];
            end

            if (m_axis_tready) begin
                m_axis_tvalid <= 1'b0;
            end

            if (accept) begin
                case (state)
                    IDLE: begin
                        if (first_ok) begin
                            m_axis_tvalid <= 1'b1;
                            m_axis_tdata  <= s_axis_tdata;
                            m_axis_tlast  <= s_axis_tlast;
                            m_route_out   <= cap_tag[s_axis_tid];
                            state         <= s_axis_tlast ? IDLE : FWD;
                        end else begin
                            drop_pulse <= 1'b1;
                            if (drop_cnt_out != '1) begin
                                drop_cnt_out <= drop_cnt_out + CNT_W'(1);
                            end
                            state <= s_axis_tlast ? IDLE : DROP;
                        end
                    end
                    FWD: begin
                        m_axis_tvalid <= 1'b1;
                        m_axis_tdata  <= s_axis_tdata;
                        m_axis_tlast  <= s_axis_tlast;
                        if (s_axis_tlast) begin
                            state <= IDLE;
                        end
                    end
                    DROP: begin
                        if (s_axis_tlast) begin
                            state <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
